// File: rtl/reg_req_encoder.sv
// reg_req_encoder: sticky 8-line request collector, round-robin encoded to a 3-bit index.
// Define ENC_ONEHOT_CHECK_EN to build the sticky multi-hot request flag on err.
module reg_req_encoder (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] req,
   input  logic       ready,
   output logic       valid,
   output logic [2:0] register,
   output logic       busy,
   output logic       err
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t     state_q, state_d;
   logic [7:0] pending_q, pending_d;
   logic [2:0] ptr_q, ptr_d;
   logic [2:0] reg_q, reg_d;
   logic       valid_q, valid_d;

   logic       accept;
   logic [7:0] clear;
   logic [7:0] cand;
   logic [2:0] scan_ptr;
   logic [2:0] idx;
   logic [2:0] sel_idx;
   logic       sel_hit;

   assign accept   = valid_q & ready;
   assign clear    = accept ? (8'h80 >> reg_q) : 8'h00;
   assign cand     = (pending_q & ~clear) | req;
   // On accept the scan starts just past the granted index, same cycle.
   assign scan_ptr = accept ? reg_q + 3'd1 : ptr_q;

   always_comb begin
      idx     = 3'd0;
      sel_idx = scan_ptr;
      sel_hit = 1'b0;
      for (int k = 7; k >= 0; k--) begin
         idx = scan_ptr + 3'(k);
         if (cand[3'd7 - idx]) begin
            sel_idx = idx;
            sel_hit = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      pending_d = cand;
      ptr_d     = ptr_q;
      reg_d     = reg_q;
      valid_d   = valid_q;
      unique case (state_q)
         IDLE: begin
            if (sel_hit) begin
               reg_d   = sel_idx;
               valid_d = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (ready) begin
               ptr_d = reg_q + 3'd1;
               if (sel_hit) begin
                  reg_d = sel_idx;
               end else begin
                  valid_d = 1'b0;
                  state_d = IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         pending_q <= 8'h00;
         ptr_q     <= 3'd0;
         reg_q     <= 3'd0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         ptr_q     <= ptr_d;
         reg_q     <= reg_d;
         valid_q   <= valid_d;
      end
   end

`ifdef ENC_ONEHOT_CHECK_EN
   logic err_q, err_d;

   // x & (x-1) is nonzero exactly when more than one bit is set.
   assign err_d = err_q | ((req & (req - 8'd1)) != 8'd0);

   always_ff @(posedge clock) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign valid    = valid_q;
   assign register = reg_q;
   assign busy     = (pending_q != 8'h00) | valid_q;

endmodule

// File: tb/tb_reg_req_encoder.sv
// tb_reg_req_encoder: directed scenarios plus randomized traffic
// checked against a set-of-pending-registers reference model.
module tb_reg_req_encoder;

   logic       clock;
   logic       reset;
   logic [7:0] req;
   logic       ready;
   logic       valid;
   logic [2:0] register;
   logic       busy;
   logic       err;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef ENC_ONEHOT_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   reg_req_encoder dut (
      .clock    (clock),
      .reset    (reset),
      .req      (req),
      .ready    (ready),
      .valid    (valid),
      .register (register),
      .busy     (busy),
      .err      (err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: pend[i] means register i is waiting.
   bit m_pend[8];
   bit m_cand[8];
   int m_ptr;
   bit m_valid;
   int m_reg;
   bit m_err;

   function automatic int pick(input int p);
      for (int k = 0; k < 8; k++) begin
         if (m_cand[(p + k) % 8]) return (p + k) % 8;
      end
      return -1;
   endfunction

   function automatic bit m_busy();
      bit any = m_valid;
      for (int i = 0; i < 8; i++) any |= m_pend[i];
      return any;
   endfunction

   task automatic model_edge();
      int ones;
      int s;
      if (reset) begin
         for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
         m_ptr = 0; m_valid = 0; m_reg = 0; m_err = 0;
         return;
      end
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         m_cand[i] = m_pend[i] | req[7-i];
         ones += int'(req[7-i]);
      end
      if (m_valid && ready) m_cand[m_reg] = req[7-m_reg];
      if (ERR_EN && ones > 1) m_err = 1'b1;
      if (!m_valid) begin
         s = pick(m_ptr);
         if (s >= 0) begin m_reg = s; m_valid = 1; end
      end else if (ready) begin
         m_ptr = (m_reg + 1) % 8;
         s = pick(m_ptr);
         if (s >= 0) m_reg = s;
         else m_valid = 0;
      end
      for (int i = 0; i < 8; i++) m_pend[i] = m_cand[i];
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      reset = 1; req = 8'h00; ready = 0;
      tick();
      reset = 0;
   endtask

   task automatic test_reset();
      reset = 1; req = 8'hFF; ready = 0;
      tick(); tick();
      n_checks++;
      if ({valid, register, busy, err} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset: v=%b r=%0d b=%b e=%b want all 0",
                  valid, register, busy, err);
      end
      reset = 0; req = 8'h00;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle[%0d]: v=%b b=%b want 0 0", i, valid, busy);
         end
      end
   endtask

   task automatic test_single();
      int exp_seq[7] = '{4, 5, 6, 7, 0, 1, 2};
      req = 8'b0010_0000; ready = 1;
      tick();
      n_checks++;
      if (valid !== 1'b1 || register !== 3'd2) begin
         n_fail++;
         $display("FAIL single_grant: v=%b r=%0d want 1 2", valid, register);
      end
      req = 8'h00;
      tick();
      n_checks++;
      if (valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_drop: v=%b want 0", valid);
      end
      req = 8'hFF;
      tick();
      req = 8'h00;
      n_checks++;
      if (valid !== 1'b1 || register !== 3'd3) begin
         n_fail++;
         $display("FAIL single_ptr: v=%b r=%0d want 1 3", valid, register);
      end
      for (int i = 0; i < 7; i++) begin
         tick();
         n_checks++;
         if (valid !== 1'b1 || register !== 3'(exp_seq[i])) begin
            n_fail++;
            $display("FAIL single_drain[%0d]: v=%b r=%0d want 1 %0d",
                     i, valid, register, exp_seq[i]);
         end
      end
      tick();
      n_checks++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_end: v=%b b=%b want 0 0", valid, busy);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      req = 8'b1000_0001; ready = 1;
      tick();
      req = 8'h00;
      n_checks++;
      if (valid !== 1'b1 || register !== 3'd0) begin
         n_fail++;
         $display("FAIL rr_first: v=%b r=%0d want 1 0", valid, register);
      end
      tick();
      n_checks++;
      if (valid !== 1'b1 || register !== 3'd7) begin
         n_fail++;
         $display("FAIL rr_second: v=%b r=%0d want 1 7", valid, register);
      end
      tick();
      n_checks++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rr_end: v=%b b=%b want 0 0", valid, busy);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      req = 8'b0001_0000; ready = 0;
      tick();
      req = 8'h00;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (valid !== 1'b1 || register !== 3'd3 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: v=%b r=%0d b=%b want 1 3 1",
                     i, valid, register, busy);
         end
         if (i < 3) tick();
      end
      ready = 1;
      tick();
      n_checks++;
      if (valid !== 1'b0 || busy !== 1'b0 || register !== 3'd3) begin
         n_fail++;
         $display("FAIL bp_accept: v=%b b=%b r=%0d want 0 0 3",
                  valid, busy, register);
      end
   endtask

   task automatic test_rearm();
      do_reset();
      req = 8'b0000_0100; ready = 0;
      tick();
      n_checks++;
      if (valid !== 1'b1 || register !== 3'd5) begin
         n_fail++;
         $display("FAIL rearm_grant: v=%b r=%0d want 1 5", valid, register);
      end
      ready = 1;
      tick();
      req = 8'h00;
      n_checks++;
      if (valid !== 1'b1 || register !== 3'd5) begin
         n_fail++;
         $display("FAIL rearm_again: v=%b r=%0d want 1 5", valid, register);
      end
      tick();
      n_checks++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rearm_end: v=%b b=%b want 0 0", valid, busy);
      end
   endtask

   task automatic test_macro();
      do_reset();
      req = 8'h81; ready = 1;
      tick();
      req = 8'h00;
      n_checks++;
      if (register !== 3'd0 || valid !== 1'b1 || err !== ERR_EN) begin
         n_fail++;
         $display("FAIL macro_g0: v=%b r=%0d e=%b want 1 0 %b",
                  valid, register, err, ERR_EN);
      end
      tick();
      n_checks++;
      if (register !== 3'd7 || valid !== 1'b1 || err !== ERR_EN) begin
         n_fail++;
         $display("FAIL macro_g7: v=%b r=%0d e=%b want 1 7 %b",
                  valid, register, err, ERR_EN);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (err !== ERR_EN || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL macro_sticky[%0d]: e=%b v=%b want %b 0",
                     i, err, valid, ERR_EN);
         end
      end
      do_reset();
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL macro_clear: e=%b want 0", err);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 199) == 0);
         case ($urandom_range(0, 3))
            0:       req = 8'($urandom);
            1:       req = 8'h80 >> $urandom_range(0, 7);
            default: req = 8'h00;
         endcase
         ready = ($urandom_range(0, 3) != 0);
         tick();
         n_checks++;
         if (valid !== m_valid || busy !== m_busy() || err !== m_err ||
             register !== 3'(m_reg)) begin
            n_fail++;
            $display("FAIL random[%0d]: v=%b r=%0d b=%b e=%b want %b %0d %b %b",
                     c, valid, register, busy, err,
                     m_valid, m_reg, m_busy(), m_err);
         end
      end
      reset = 0; req = 8'h00; ready = 0;
   endtask

   initial begin
      reset = 1; req = 8'h00; ready = 0;
      m_ptr = 0; m_valid = 0; m_reg = 0; m_err = 0;
      for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_rearm();
      test_macro();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
